jedro_1_ifu: RTL
================

// Module: jedro_1_ifu
// PURPOSE
//  Instruction fetch unit of the jedro_1 core; sits between the instruction ROM and the decoder.
//  Drives word addresses to the synchronous-read ROM and buffers returned words with their PCs in a prefetch FIFO.
//  Presents instructions to the decoder over a valid/ready handshake.
//  Accepts jump/branch redirects from the execute stage: flushes buffered and in-flight fetches, restarts at the target.
// PARAMETERS
//  BOOT_ADDR   32'h0000_0000  first fetch address after reset
//  FIFO_DEPTH  2              prefetch entries; power of two, >= 2
// PORTS
//  clk_i              in   1   core clock
//  rstn_i             in   1   reset, asynchronous, active-low
//  iram_addr_o        out  32  ROM byte address; ROM returns data one cycle later
//  iram_rdata_i       in   32  ROM read data
//  instr_o            out  32  instruction at FIFO head
//  addr_o             out  32  PC of instr_o
//  instr_valid_o      out  1   FIFO head valid
//  dec_ready_i        in   1   decoder accepts head this cycle
//  jmp_addr_i         in   32  redirect target
//  jmp_addr_valid_i   in   1   redirect request, single-cycle pulse
//  jmp_misaligned_o   out  1   one-cycle pulse: last redirect target had [1:0]!=0
// BEHAVIOUR
//  Reset (async assert): fetch_pc=BOOT_ADDR, inflight=0, FIFO empty; iram_addr_o=BOOT_ADDR;
//  instr_o=0, addr_o=0, instr_valid_o=0, jmp_misaligned_o=0.
//  iram_addr_o is fetch_pc (registered). pop = instr_valid_o & dec_ready_i.
//  issue = !jmp_addr_valid_i & (count + inflight - pop < FIFO_DEPTH).
//  On issue: fetch_pc += 4, wraps 0xFFFF_FFFC -> 0.
//  inflight_q <= issue; inflight_pc_q <= fetch_pc.
//  No issue: address held; ROM re-reads it; the response is ignored.
//  Response: if inflight_q & no redirect this cycle, push {inflight_pc_q, iram_rdata_i}. Push and pop may coincide.
//  Overflow is impossible by the credit rule; a push into a full FIFO is an assertion failure.
//  Latency: first issue in the first cycle with rstn_i=1; instr_valid_o rises 2 cycles later.
//  Throughput: 1 instr/cycle with dec_ready_i=1 at FIFO_DEPTH>=2.
//  Redirect (jmp_addr_valid_i=1 in cycle N): FIFO flushed and inflight_q cleared at edge N.
//  Redirect also drops a response arriving in cycle N; pop in cycle N is ignored (flush wins).
//  fetch_pc <= {jmp_addr_i[31:2],2'b00}. jmp_misaligned_o=|jmp_addr_i[1:0] in N+1.
//  instr_valid_o=0 in N+1 and N+2; target visible in N+3.
//  Redirect in N+1/N+2 restarts the sequence; only the last target is ever delivered.
//  instr_o/addr_o hold the head entry; they are don't-care while instr_valid_o=0.
//  Deasserting dec_ready_i never loses or duplicates an instruction.
//  Reset asserted mid-operation: all state returns to reset values immediately, without a clock edge.
// STRUCTURE
//  jedro_1_defines package: DATA_WIDTH=32, ADDR_WIDTH=32, BOOT_ADDR_DEFAULT.
//  jedro_1_defines package: typedef struct packed {logic[31:0] pc; logic[31:0] instr;} fetch_entry_t.
//  Sub-module jedro_1_ifu_fifo: synchronous FIFO of fetch_entry_t with push, pop, flush (flush dominant), count, empty, full.
//  Top: fetch_pc/inflight registers, credit logic, redirect handling.
// TESTING (ROM word k holds value k)
//  1 Release reset, dec_ready_i=1 -> instr_valid_o rises 2 cycles after release; addr_o 0,4,8,... and instr_o 0,1,2,... each cycle.
//  2 dec_ready_i=0 for 10 cycles -> FIFO holds PCs 0,4; iram_addr_o holds 8; on release 0,4,8,... with no gap, loss or duplicate.
//  3 jmp_addr_i=0x40 pulse while FIFO full -> instr_valid_o=0 for 2 cycles; then addr_o=0x40, instr_o=0x10, then 0x44.
//  4 jmp_addr_i=0x42 -> jmp_misaligned_o=1 for one cycle; delivery resumes at addr_o=0x40.
//  5 Redirect with dec_ready_i=1 and instr_valid_o=1 in the same cycle -> head neither consumed nor re-presented; next PC delivered is the target.
//  6 rstn_i low mid-run, no clock edge -> outputs at reset values at once; after release, fetch restarts at BOOT_ADDR.

Source files
------------

// File: rtl/jedro_1_defines.sv
// jedro_1 shared definitions: bus widths, boot address and the
// fetch entry carried from the IFU prefetch buffer to decode.
package jedro_1_defines;

    localparam int unsigned DATA_WIDTH = 32;
    localparam int unsigned ADDR_WIDTH = 32;

    localparam logic [ADDR_WIDTH-1:0] BOOT_ADDR_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] pc;
        logic [DATA_WIDTH-1:0] instr;
    } fetch_entry_t;

    function automatic logic [ADDR_WIDTH-1:0] word_align(
        input logic [ADDR_WIDTH-1:0] a
    );
        return {a[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/jedro_1_ifu_fifo.sv
// Prefetch FIFO of fetch entries; flush dominates push and pop.
// DEPTH must be a power of two so the pointers wrap naturally.
module jedro_1_ifu_fifo
    import jedro_1_defines::*;
#(
    parameter int unsigned DEPTH = 2,
    localparam int unsigned AW = $clog2(DEPTH)
) (
    input  logic         clk_i,
    input  logic         rstn_i,
    input  logic         flush_i,
    input  logic         push_i,
    input  fetch_entry_t data_i,
    input  logic         pop_i,
    output fetch_entry_t data_o,
    output logic [AW:0]  count_o,
    output logic         empty_o,
    output logic         full_o
);

    localparam logic [AW:0] DEPTH_C = DEPTH[AW:0];

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  mem_d [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == DEPTH_C);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = data_i;
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            count_d = count_q
                    + {{AW{1'b0}}, do_push}
                    - {{AW{1'b0}}, do_pop};
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/jedro_1_ifu.sv
// jedro_1 instruction fetch: drives the synchronous ROM, buffers words
// with their PCs and hands them to decode; redirects flush everything.
module jedro_1_ifu
    import jedro_1_defines::*;
#(
    parameter logic [ADDR_WIDTH-1:0] BOOT_ADDR  = BOOT_ADDR_DEFAULT,
    parameter int unsigned           FIFO_DEPTH = 2
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    output logic [31:0] iram_addr_o,
    input  logic [31:0] iram_rdata_i,
    output logic [31:0] instr_o,
    output logic [31:0] addr_o,
    output logic        instr_valid_o,
    input  logic        dec_ready_i,
    input  logic [31:0] jmp_addr_i,
    input  logic        jmp_addr_valid_i,
    output logic        jmp_misaligned_o
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 2;

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [31:0]   inflight_pc_q, inflight_pc_d;
    logic          inflight_q, inflight_d;
    logic          misaligned_q, misaligned_d;

    logic          pop, push, issue;
    logic [CW-1:0] credit;
    logic [AW:0]   fifo_count;
    logic          fifo_empty, fifo_full;
    fetch_entry_t  head, resp;

    assign resp   = '{pc: inflight_pc_q, instr: iram_rdata_i};
    assign pop    = instr_valid_o & dec_ready_i;
    assign push   = inflight_q & ~jmp_addr_valid_i;

    // Slots already claimed, counting the word still in the ROM pipe.
    assign credit = CW'(fifo_count) + CW'(inflight_q) - CW'(pop);
    assign issue  = ~jmp_addr_valid_i & (credit < CW'(FIFO_DEPTH));

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        inflight_d    = issue;
        inflight_pc_d = fetch_pc_q;
        misaligned_d  = jmp_addr_valid_i & (|jmp_addr_i[1:0]);
        if (jmp_addr_valid_i) begin
            fetch_pc_d = word_align(jmp_addr_i);
        end else if (issue) begin
            fetch_pc_d = fetch_pc_q + 32'd4;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            fetch_pc_q    <= BOOT_ADDR;
            inflight_pc_q <= '0;
            inflight_q    <= 1'b0;
            misaligned_q  <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            inflight_pc_q <= inflight_pc_d;
            inflight_q    <= inflight_d;
            misaligned_q  <= misaligned_d;
        end
    end

    jedro_1_ifu_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rstn_i  (rstn_i),
        .flush_i (jmp_addr_valid_i),
        .push_i  (push),
        .data_i  (resp),
        .pop_i   (pop),
        .data_o  (head),
        .count_o (fifo_count),
        .empty_o (fifo_empty),
        .full_o  (fifo_full)
    );

    assign iram_addr_o      = fetch_pc_q;
    assign instr_o          = head.instr;
    assign addr_o           = head.pc;
    assign instr_valid_o    = ~fifo_empty;
    assign jmp_misaligned_o = misaligned_q;

    a_no_overflow: assert property (
        @(posedge clk_i) disable iff (!rstn_i) !(push && fifo_full)
    );

endmodule
